vel_profile_sequencer: RTL and testbench
========================================

# vel_profile_sequencer

Motion sequencer that drives the `desired_vel` input of the PI velocity loop and gates the loop on and off. On a start command it ramps the setpoint to a target velocity in a trapezoidal profile, one fixed step per control tick, then holds the target. On a stop command it ramps the setpoint back to zero. It watches tracking error for stalls and handles emergency stop with a sticky fault. It sits between the AXI register block and the velocity controller.

## Interface
Parameters:
- `TICK_DIV`, 5000: clk cycles per control tick (100 MHz / 5000 = 20 kHz).
- `STALL_TICKS`, 2000: consecutive out-of-tolerance ticks in CRUISE that raise a stall fault.

Ports:
- `clk` input 1: system clock, 100 MHz.
- `reset_n` input 1: asynchronous reset, active-low. This is the only reset.
- `start` input 1: start request, level-sampled each clk.
- `stop` input 1: controlled stop request.
- `estop` input 1: emergency stop.
- `fault_clr` input 1: clears FAULT.
- `target_vel` input 32 signed: cruise velocity, latched on an accepted start.
- `accel_step` input 16 unsigned: setpoint change per tick. A value of 0 is treated as 1.
- `actual_vel` input 32 signed: measured velocity from the velocity controller.
- `stall_thresh` input 32 unsigned: allowed |desired − actual| in CRUISE.
- `desired_vel` output 32 signed: setpoint to the PI loop.
- `loop_en` output 1: high in RAMP, CRUISE and DECEL.
- `busy` output 1: high whenever state ≠ IDLE.
- `done` output 1: one-cycle pulse when DECEL completes.
- `fault` output 1: high in FAULT.
- `state` output 3: current state code.

## Operation
- Tick generation:
  - A free-running counter counts 0..TICK_DIV−1 from reset.
  - `tick` is a one-cycle enable when the count equals TICK_DIV−1.
  - There are no derived clocks. All logic runs on `clk` and is qualified by `tick` where noted.
- States and codes: IDLE=0, RAMP=1, CRUISE=2, DECEL=3, FAULT=4.
- IDLE:
  - `desired_vel`=0, `loop_en`=0.
  - `start`=1 with `target_vel`≠0: latch `target_vel` into `tgt_r` and go to RAMP.
  - `start`=1 with `target_vel`=0: pulse `done`, stay in IDLE.
- RAMP, evaluated on each tick:
  - d = `tgt_r` − `desired_vel`, computed at 33 bits.
  - If |d| ≤ step: `desired_vel` ← `tgt_r` and go to CRUISE.
  - Otherwise: `desired_vel` ← `desired_vel` ± step, moving toward `tgt_r`.
- CRUISE:
  - `desired_vel` holds `tgt_r`.
  - Each tick, if |`desired_vel` − `actual_vel`| > `stall_thresh` (33-bit compare), increment `stall_cnt`; otherwise clear it.
  - When `stall_cnt` reaches STALL_TICKS, go to FAULT.
  - `stall_cnt` is cleared on entry to CRUISE.
- DECEL, evaluated on each tick:
  - Same step rule as RAMP, with a target of 0.
  - On reaching 0: go to IDLE and pulse `done` in the same cycle.
- `stop`=1 in RAMP or CRUISE: go to DECEL. The ramp continues from the current `desired_vel`.
- FAULT:
  - `desired_vel`=0 and `loop_en`=0 immediately.
  - `fault_clr`=1 with `estop`=0 returns to IDLE. FAULT is left only this way.
- Priority within one cycle: `estop` > stall > `stop` > ramp/hold progress > `start`.
- `estop` forces FAULT from any state, including FAULT itself.
- `start` is ignored outside IDLE. `stop` is ignored in IDLE, DECEL and FAULT.
- Arithmetic:
  - The ±step result never overshoots the target; this is guaranteed by the |d| ≤ step test.
  - Intermediate sums are 33 bits wide. `desired_vel` saturates to the 32-bit signed range.

## Timing
- Reset values: `desired_vel`=0, `loop_en`=0, `busy`=0, `done`=0, `fault`=0, `state`=0, tick counter=0, `tgt_r`=0, `stall_cnt`=0.
- `reset_n` low mid-operation forces all of the above asynchronously. There is no profile resume after reset.
- An accepted `start` in cycle N gives `state`=RAMP, `loop_en`=1 and `busy`=1 in cycle N+1.
- The first setpoint step happens on the first tick after N+1.
- The tick phase is not realigned to `start`, so the first step arrives 1 to TICK_DIV cycles after entering RAMP.
- All outputs are registered and update one clk after the decision edge.
- `estop` in cycle N gives FAULT, `desired_vel`=0 and `loop_en`=0 in cycle N+1.
- `done` is exactly one cycle wide and coincides with the first IDLE cycle.
- `loop_en` is 0 in that same cycle.

## Structure
- Shared package `motor_ctrl_pkg` holds:
  - the state encoding constants (IDLE..FAULT);
  - the default `TICK_DIV`;
  - the 32-bit velocity width constant.
- Sub-module `tick_gen`: a parameterised clock-enable divider producing `tick`. It is reusable by the PI loop to replace its derived clock.
- The state machine, step arithmetic and stall counter stay in `vel_profile_sequencer`.

## Test plan
- Up-ramp: TICK_DIV=10, `target_vel`=1000, `accel_step`=100, pulse `start`.
  - `desired_vel` goes 100, 200 … 1000, one step per tick.
  - CRUISE is entered on the 10th tick, with `loop_en`=1 throughout.
- Negative target with remainder: `target_vel`=−250, `accel_step`=100.
  - `desired_vel` goes −100, −200, −250, then CRUISE, with no overshoot.
- Controlled stop: assert `stop` in CRUISE at 1000 with step 100.
  - `desired_vel` goes 900 … 0.
  - IDLE is reached with a single-cycle `done` and `loop_en`=0 in that cycle.
- Stall: STALL_TICKS=4, `stall_thresh`=50, `actual_vel` held at 0 in CRUISE at 1000.
  - FAULT is entered one cycle after the 4th tick, with `fault`=1 and `desired_vel`=0.
  - `fault_clr` then returns to IDLE.
- E-stop and clear: `estop` mid-RAMP at `desired_vel`=300.
  - Next cycle: FAULT with `desired_vel`=0.
  - `start` is ignored while in FAULT.
  - `fault_clr` with `estop` still high keeps FAULT; releasing `estop` then `fault_clr` gives IDLE.
- Reset mid-RAMP plus edge cases: drop `reset_n` mid-RAMP.
  - All outputs go to 0 and `state`=IDLE without waiting for a clk edge.
  - After release, `accel_step`=0 with target 3 gives a ramp of 1, 2, 3.

Source files
------------

// File: rtl/motor_ctrl_pkg.sv
// Shared motion-control definitions: state codes, velocity width, default tick divider
// and the wide-arithmetic helpers used by the setpoint ramp.
package motor_ctrl_pkg;

  localparam int VEL_W        = 32;
  localparam int TICK_DIV_DEF = 5000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RAMP   = 3'd1,
    ST_CRUISE = 3'd2,
    ST_DECEL  = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  // Differences of two 32-bit signed values never reach -2^32, so negation cannot wrap.
  function automatic logic [VEL_W:0] abs_wide(input logic signed [VEL_W:0] v);
    if (v < 33'sd0) begin
      abs_wide = -v;
    end else begin
      abs_wide = v;
    end
  endfunction

  function automatic logic signed [VEL_W-1:0] sat_vel(input logic signed [VEL_W:0] v);
    if (v > 33'sh0_7FFF_FFFF) begin
      sat_vel = 32'sh7FFF_FFFF;
    end else if (v < 33'sh1_8000_0000) begin
      sat_vel = 32'sh8000_0000;
    end else begin
      sat_vel = v[VEL_W-1:0];
    end
  endfunction

endpackage

// File: rtl/vel_profile_sequencer_if.sv
// Command, feedback and setpoint bundle between the register block / velocity loop
// (master side) and the profile sequencer (slave side).
interface vel_profile_sequencer_if;
  logic               start;
  logic               stop;
  logic               estop;
  logic               fault_clr;
  logic signed [31:0] target_vel;
  logic        [15:0] accel_step;
  logic signed [31:0] actual_vel;
  logic        [31:0] stall_thresh;
  logic signed [31:0] desired_vel;
  logic               loop_en;
  logic               busy;
  logic               done;
  logic               fault;
  logic        [2:0]  state;

  modport master (
    output start, stop, estop, fault_clr, target_vel, accel_step, actual_vel, stall_thresh,
    input  desired_vel, loop_en, busy, done, fault, state
  );

  modport slave (
    input  start, stop, estop, fault_clr, target_vel, accel_step, actual_vel, stall_thresh,
    output desired_vel, loop_en, busy, done, fault, state
  );
endinterface

// File: rtl/vel_profile_sequencer_tick_gen.sv
// Free-running clock-enable divider: tick is high for one clk out of every DIV,
// while the internal count equals DIV-1.
module tick_gen #(
  parameter int DIV = 5000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);
  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // wrap at DIV-1; tick is registered from the next count so it lines up with cnt_q==LAST
  always_comb begin
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    tick_d = (cnt_d == LAST);
  end

  // divider state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
endmodule

// File: rtl/vel_profile_sequencer.sv
// Trapezoidal setpoint sequencer for the PI velocity loop: ramps to a latched target,
// holds it while watching for stalls, ramps back to zero on stop, sticky fault on estop.
module vel_profile_sequencer
  import motor_ctrl_pkg::*;
#(
  parameter int TICK_DIV    = TICK_DIV_DEF,
  parameter int STALL_TICKS = 2000
) (
  input logic                    clk,
  input logic                    reset_n,
  vel_profile_sequencer_if.slave bus
);
  typedef logic signed [VEL_W:0] wide_t;
  localparam logic [31:0] STALL_LIM = 32'(STALL_TICKS);

  logic                    tick_s;
  state_e                  state_q, state_d;
  logic signed [VEL_W-1:0] desired_q, desired_d, tgt_q, tgt_d;
  logic [31:0]             stall_cnt_q, stall_cnt_d, stall_inc_s;
  logic                    done_q, done_d, loop_en_q, loop_en_d;
  logic                    busy_q, busy_d, fault_q, fault_d;
  wide_t                   step_s, ramp_tgt_s, cur_s, diff_s, moved_s, err_s;
  logic                    arrive_s, over_s;

  tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick_s)
  );

  // step toward the ramp target (tgt in RAMP, zero in DECEL) and stall-error evaluation
  always_comb begin
    step_s      = (bus.accel_step == 16'd0) ? 33'sd1 : wide_t'({17'd0, bus.accel_step});
    ramp_tgt_s  = (state_q == ST_DECEL) ? 33'sd0 : wide_t'({tgt_q[VEL_W-1], tgt_q});
    cur_s       = {desired_q[VEL_W-1], desired_q};
    diff_s      = ramp_tgt_s - cur_s;
    arrive_s    = (abs_wide(diff_s) <= $unsigned(step_s));
    moved_s     = diff_s[VEL_W] ? (cur_s - step_s) : (cur_s + step_s);
    err_s       = cur_s - {bus.actual_vel[VEL_W-1], bus.actual_vel};
    over_s      = (abs_wide(err_s) > {1'b0, bus.stall_thresh});
    stall_inc_s = over_s ? (stall_cnt_q + 32'd1) : 32'd0;
  end

  // next-state decision: estop > stall > stop > ramp/hold progress > start
  always_comb begin
    state_d     = state_q;
    desired_d   = desired_q;
    tgt_d       = tgt_q;
    stall_cnt_d = stall_cnt_q;
    done_d      = 1'b0;
    if (bus.estop) begin
      state_d     = ST_FAULT;
      desired_d   = '0;
      stall_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          desired_d = '0;
          if (bus.start && (bus.target_vel != 32'sd0)) begin
            tgt_d   = bus.target_vel;
            state_d = ST_RAMP;
          end else if (bus.start) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RAMP: begin
          if (bus.stop) begin
            state_d = ST_DECEL;
          end else if (tick_s && arrive_s) begin
            desired_d   = tgt_q;
            stall_cnt_d = '0;
            state_d     = ST_CRUISE;
          end else if (tick_s) begin
            desired_d = sat_vel(moved_s);
          end else begin
            state_d = ST_RAMP;
          end
        end
        ST_CRUISE: begin
          desired_d = tgt_q;
          if (tick_s && (stall_inc_s >= STALL_LIM)) begin
            state_d     = ST_FAULT;
            desired_d   = '0;
            stall_cnt_d = '0;
          end else if (bus.stop) begin
            state_d = ST_DECEL;
          end else if (tick_s) begin
            stall_cnt_d = stall_inc_s;
          end else begin
            state_d = ST_CRUISE;
          end
        end
        ST_DECEL: begin
          if (tick_s && arrive_s) begin
            desired_d = '0;
            state_d   = ST_IDLE;
            done_d    = 1'b1;
          end else if (tick_s) begin
            desired_d = sat_vel(moved_s);
          end else begin
            state_d = ST_DECEL;
          end
        end
        ST_FAULT: begin
          desired_d = '0;
          if (bus.fault_clr) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FAULT;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          desired_d = '0;
        end
      endcase
    end
    loop_en_d = (state_d == ST_RAMP) || (state_d == ST_CRUISE) || (state_d == ST_DECEL);
    busy_d    = (state_d != ST_IDLE);
    fault_d   = (state_d == ST_FAULT);
  end

  // sequencer state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      desired_q   <= '0;
      tgt_q       <= '0;
      stall_cnt_q <= '0;
      done_q      <= 1'b0;
      loop_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      desired_q   <= desired_d;
      tgt_q       <= tgt_d;
      stall_cnt_q <= stall_cnt_d;
      done_q      <= done_d;
      loop_en_q   <= loop_en_d;
      busy_q      <= busy_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.desired_vel = desired_q;
  assign bus.loop_en     = loop_en_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.fault       = fault_q;
  assign bus.state       = state_q;
endmodule

// File: tb/tb_vel_profile_sequencer.sv
// Self-checking bench: table of ramp vectors, hand-written corner sequences and a
// randomized phase, all compared every cycle against a behavioural profile model.
module tb_vel_profile_sequencer;
  localparam int TD = 10;
  localparam int ST = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  vel_profile_sequencer_if bus();

  vel_profile_sequencer #(.TICK_DIV(TD), .STALL_TICKS(ST)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // behavioural model: 0 idle, 1 ramp, 2 cruise, 3 decel, 4 fault
  int     m_state, m_cnt, m_stall;
  longint m_des, m_tgt;
  bit     m_done;

  typedef struct {
    logic signed [31:0] target;
    logic [15:0]        step;
    int                 exp_steps;
    logic signed [31:0] exp_first;
  } ramp_vec_t;
  ramp_vec_t tbl[6];

  function automatic longint approach(longint cur, longint tgt, longint s);
    longint d = tgt - cur;
    if (((d < 0) ? -d : d) <= s) return tgt;
    return (d > 0) ? cur + s : cur - s;
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_stall = 0; m_des = 0; m_tgt = 0; m_done = 1'b0;
  endtask

  task automatic model_step();
    bit     tk;
    longint s, err;
    tk     = (m_cnt == TD - 1);
    m_cnt  = tk ? 0 : m_cnt + 1;
    s      = (bus.accel_step == 16'd0) ? 64'sd1 : longint'(bus.accel_step);
    m_done = 1'b0;
    if (bus.estop) begin
      m_state = 4; m_des = 0;
    end else begin
      case (m_state)
        0: if (bus.start) begin
             if (bus.target_vel != 32'sd0) begin m_tgt = longint'(bus.target_vel); m_state = 1; end
             else m_done = 1'b1;
           end
        1: if (bus.stop) m_state = 3;
           else if (tk) begin
             m_des = approach(m_des, m_tgt, s);
             if (m_des == m_tgt) begin m_state = 2; m_stall = 0; end
           end
        2: begin
             if (tk) begin
               err = m_des - longint'(bus.actual_vel);
               if (err < 0) err = -err;
               m_stall = (err > longint'(bus.stall_thresh)) ? m_stall + 1 : 0;
             end
             if (tk && m_stall >= ST) begin m_state = 4; m_des = 0; end
             else if (bus.stop) m_state = 3;
           end
        3: if (tk) begin
             m_des = approach(m_des, 0, s);
             if (m_des == 0) begin m_state = 0; m_done = 1'b1; end
           end
        4: if (bus.fault_clr) m_state = 0;
        default: m_state = 0;
      endcase
    end
  endtask

  function automatic logic [38:0] obs_vec();
    return {bus.desired_vel, bus.loop_en, bus.busy, bus.done, bus.fault, bus.state};
  endfunction

  function automatic logic [38:0] exp_vec();
    logic [31:0] d = m_des[31:0];
    return {d, (m_state >= 1 && m_state <= 3), (m_state != 0), m_done, (m_state == 4), 3'(m_state)};
  endfunction

  task automatic check_vec(string name, logic [38:0] got, logic [38:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  task automatic check_val(string name, longint got, longint exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got=%0d expected=%0d", name, $time, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_vec("model", obs_vec(), exp_vec());
  endtask

  task automatic run_ramp(input int i);
    int     nsteps = 0;
    longint first  = 0;
    longint prev;
    bus.target_vel   = tbl[i].target;
    bus.accel_step   = tbl[i].step;
    bus.actual_vel   = tbl[i].target;
    bus.stall_thresh = 32'd50;
    bus.start        = 1'b1;
    cyc();
    bus.start = 1'b0;
    check_val("ramp_enter_state", longint'(bus.state), 1);
    check_val("ramp_enter_loop_en", longint'(bus.loop_en), 1);
    prev = longint'(bus.desired_vel);
    for (int k = 0; k < 400 && bus.state != 3'd2; k++) begin
      cyc();
      if (longint'(bus.desired_vel) != prev) begin
        nsteps++;
        if (nsteps == 1) first = longint'(bus.desired_vel);
        prev = longint'(bus.desired_vel);
      end
    end
    check_val("ramp_reach_cruise", longint'(bus.state), 2);
    check_val("ramp_step_count", nsteps, tbl[i].exp_steps);
    check_val("ramp_first_step", first, longint'(tbl[i].exp_first));
    check_val("ramp_final", longint'(bus.desired_vel), longint'(tbl[i].target));
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    check_val("stop_to_decel", longint'(bus.state), 3);
    for (int k = 0; k < 400 && bus.state != 3'd0; k++) cyc();
    check_val("decel_idle", longint'(bus.state), 0);
    check_val("decel_done", longint'(bus.done), 1);
    check_val("decel_loop_en", longint'(bus.loop_en), 0);
    check_val("decel_zero", longint'(bus.desired_vel), 0);
    cyc();
    check_val("done_width", longint'(bus.done), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    int tv;
    tbl[0] = '{32'sd1000, 16'd100, 10, 32'sd100};
    tbl[1] = '{-32'sd250, 16'd100, 3, -32'sd100};
    tbl[2] = '{32'sd3,    16'd0,   3, 32'sd1};
    tbl[3] = '{32'sd7,    16'd10,  1, 32'sd7};
    tbl[4] = '{-32'sd1,   16'd0,   1, -32'sd1};
    tbl[5] = '{32'sd500,  16'd200, 3, 32'sd200};

    bus.start = 1'b0; bus.stop = 1'b0; bus.estop = 1'b0; bus.fault_clr = 1'b0;
    bus.target_vel = 32'sd0; bus.accel_step = 16'd0; bus.actual_vel = 32'sd0;
    bus.stall_thresh = 32'd0;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_vec("reset_state", obs_vec(), 39'd0);
    reset_n = 1'b1;
    repeat (3) cyc();

    // start with zero target: done pulse, no motion
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check_val("zero_tgt_done", longint'(bus.done), 1);
    check_val("zero_tgt_idle", longint'(bus.state), 0);
    cyc();

    for (int i = 0; i < 6; i++) run_ramp(i);

    // stall: actual held at 0 while cruising at 1000
    bus.target_vel = 32'sd1000; bus.accel_step = 16'd100;
    bus.actual_vel = 32'sd0; bus.stall_thresh = 32'd50;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int k = 0; k < 200 && bus.state != 3'd2; k++) cyc();
    check_val("stall_cruise", longint'(bus.state), 2);
    cnt = 0;
    for (int k = 0; k < 100 && bus.state != 3'd4; k++) begin cyc(); cnt++; end
    check_val("stall_latency", cnt, 4 * TD);
    check_val("stall_fault", longint'(bus.fault), 1);
    check_val("stall_desired", longint'(bus.desired_vel), 0);
    bus.fault_clr = 1'b1;
    cyc();
    bus.fault_clr = 1'b0;
    check_val("stall_clr_idle", longint'(bus.state), 0);

    // estop mid-ramp at 300
    bus.actual_vel = 32'sd0; bus.stall_thresh = 32'd5000;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int k = 0; k < 200 && bus.desired_vel != 32'sd300; k++) cyc();
    check_val("estop_pre", longint'(bus.desired_vel), 300);
    bus.estop = 1'b1;
    cyc();
    check_val("estop_state", longint'(bus.state), 4);
    check_val("estop_desired", longint'(bus.desired_vel), 0);
    check_val("estop_loop_en", longint'(bus.loop_en), 0);
    bus.start = 1'b1; bus.target_vel = 32'sd500;
    cyc();
    bus.start = 1'b0;
    check_val("fault_ignore_start", longint'(bus.state), 4);
    bus.fault_clr = 1'b1;
    cyc();
    check_val("clr_with_estop", longint'(bus.state), 4);
    bus.estop = 1'b0; bus.fault_clr = 1'b0;
    cyc();
    check_val("fault_sticky", longint'(bus.state), 4);
    bus.fault_clr = 1'b1;
    cyc();
    bus.fault_clr = 1'b0;
    check_val("fault_clr_idle", longint'(bus.state), 0);

    // asynchronous reset mid-ramp, then accel_step=0 edge case
    bus.target_vel = 32'sd1000; bus.accel_step = 16'd100;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int k = 0; k < 200 && bus.desired_vel < 32'sd200; k++) cyc();
    #2;
    reset_n = 1'b0;
    #1;
    check_vec("async_reset", obs_vec(), 39'd0);
    model_reset();
    @(posedge clk);
    #1;
    check_vec("reset_hold", obs_vec(), exp_vec());
    reset_n = 1'b1;
    run_ramp(2);

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      bus.start     = ($urandom_range(0, 7) == 0);
      bus.stop      = ($urandom_range(0, 39) == 0);
      bus.estop     = ($urandom_range(0, 299) == 0);
      bus.fault_clr = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 9))
        0: bus.target_vel = 32'sd0;
        1: bus.target_vel = 32'sh7FFF_FFFF;
        2: bus.target_vel = 32'sh8000_0000;
        default: begin
          tv = int'($urandom_range(0, 4000)) - 2000;
          bus.target_vel = tv;
        end
      endcase
      bus.accel_step   = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 400));
      tv               = int'(m_des) + int'($urandom_range(0, 300)) - 150;
      bus.actual_vel   = tv;
      bus.stall_thresh = 32'($urandom_range(0, 200));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
